// File: rtl/mouse_pkg.sv
// Shared types for the mouse cursor controller.
// FSM states, event record and FIFO sizing.
package mouse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC_X,
    CALC_Y,
    EVENT
  } state_e;

  typedef struct packed {
    logic [2:0] btn_new;
    logic [2:0] btn_changed;
  } evt_t;

  localparam int EVT_FIFO_DEPTH = 4;
  localparam int EVT_W = $bits(evt_t);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mouse_cursor_ctrl_if.sv
// Packet input and event output bundle.
// slave = controller side, master = host side.
interface mouse_cursor_ctrl_if;

  logic       pkt_valid_i;
  logic [8:0] dx_i;
  logic [8:0] dy_i;
  logic [2:0] btn_i;
  logic       evt_valid_o;
  logic [5:0] evt_data_o;
  logic       evt_ack_i;

  modport slave (
    input  pkt_valid_i,
    input  dx_i,
    input  dy_i,
    input  btn_i,
    input  evt_ack_i,
    output evt_valid_o,
    output evt_data_o
  );

  modport master (
    output pkt_valid_i,
    output dx_i,
    output dy_i,
    output btn_i,
    output evt_ack_i,
    input  evt_valid_o,
    input  evt_data_o
  );

endinterface

// File: rtl/mouse_evt_fifo.sv
// First-word fall-through event FIFO.
// Push while full succeeds only with a same-cycle pop.
module mouse_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];

  // Pointer and occupancy bookkeeping.
  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mouse_cursor_ctrl.sv
// PS/2 mouse cursor tracker with clamped X/Y,
// button-change event FIFO and sticky error flags.
module mouse_cursor_ctrl
  import mouse_pkg::*;
#(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int X_POS_WIDTH = 10,
  parameter int Y_POS_WIDTH = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  mouse_cursor_ctrl_if.slave     bus,
  input  logic                   center_i,
  input  logic                   clr_i,
  output logic [X_POS_WIDTH:0]   x_pos_o,
  output logic [Y_POS_WIDTH:0]   y_pos_o,
  output logic                   irq_o,
  output logic                   drop_o,
  output logic                   ovf_o
);

  localparam int XW = X_POS_WIDTH;
  localparam int YW = Y_POS_WIDTH;
  localparam int PW = max2(XW, YW) + 1;
  localparam int AW = max2(XW, YW) + 3;

  localparam logic [AW-1:0] W_LIM = AW'(WIDTH);
  localparam logic [AW-1:0] H_LIM = AW'(HEIGHT);
  localparam logic [PW-1:0] W_MAX = PW'(WIDTH - 1);
  localparam logic [PW-1:0] H_MAX = PW'(HEIGHT - 1);
  localparam logic [XW:0]   X_MID = (XW + 1)'(WIDTH / 2);
  localparam logic [YW:0]   Y_MID = (YW + 1)'(HEIGHT / 2);

  state_e        state_q, state_d;
  logic [8:0]    dx_q, dy_q;
  logic [2:0]    btn_q, btn_prev_q;
  logic [XW:0]   x_q, x_d;
  logic [YW:0]   y_q, y_d;
  logic          drop_q, drop_d;
  logic          ovf_q, ovf_d;

  logic          idle;
  logic          accept;
  logic          center_go;
  logic          drop_set;
  logic          ovf_set;
  logic          push;
  evt_t          evt;

  logic          sub;
  logic [AW-1:0] op_a, op_b, sum, lim;
  logic [PW-1:0] clamp;

  logic [EVT_W-1:0] fifo_data;
  logic             fifo_full;
  logic             fifo_empty;

  assign idle      = (state_q == IDLE);
  assign accept    = idle && bus.pkt_valid_i && !center_i;
  assign center_go = idle && center_i;
  assign drop_set  = bus.pkt_valid_i && (!idle || center_i);

  assign evt.btn_new     = btn_q;
  assign evt.btn_changed = btn_q ^ btn_prev_q;
  assign push            = (state_q == EVENT) && (|evt.btn_changed);
  assign ovf_set         = push && fifo_full && !bus.evt_ack_i;

  // Shared adder: x+dx in CALC_X, y-dy in CALC_Y, then clamp.
  always_comb begin
    sub  = (state_q == CALC_Y);
    op_a = sub ? {{(AW-YW-1){1'b0}}, y_q}
               : {{(AW-XW-1){1'b0}}, x_q};
    op_b = sub ? ~{{(AW-9){dy_q[8]}}, dy_q}
               :  {{(AW-9){dx_q[8]}}, dx_q};
    sum  = op_a + op_b + {{(AW-1){1'b0}}, sub};
    lim  = sub ? H_LIM : W_LIM;
    if (sum[AW-1]) begin
      clamp = '0;
    end else if (sum >= lim) begin
      clamp = sub ? H_MAX : W_MAX;
    end else begin
      clamp = sum[PW-1:0];
    end
  end

  // Next state and next register values.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC_X;
      CALC_X:  state_d = CALC_Y;
      CALC_Y:  state_d = EVENT;
      EVENT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (center_go) begin
      x_d = X_MID;
      y_d = Y_MID;
    end else if (state_q == CALC_X) begin
      x_d = clamp[XW:0];
    end else if (state_q == CALC_Y) begin
      y_d = clamp[YW:0];
    end
    if (clr_i) begin
      drop_d = 1'b0;
      ovf_d  = 1'b0;
    end
    if (drop_set) drop_d = 1'b1;
    if (ovf_set)  ovf_d  = 1'b1;
  end

  // State, position and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      btn_prev_q <= '0;
      drop_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      if (state_q == EVENT) begin
        btn_prev_q <= btn_q;
      end
    end
  end

  // Packet capture on acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dx_q  <= '0;
      dy_q  <= '0;
      btn_q <= '0;
    end else if (accept) begin
      dx_q  <= bus.dx_i;
      dy_q  <= bus.dy_i;
      btn_q <= bus.btn_i;
    end
  end

  mouse_evt_fifo #(
    .DEPTH (EVT_FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (evt),
    .pop_i   (bus.evt_ack_i),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.evt_valid_o = !fifo_empty;
  assign bus.evt_data_o  = fifo_data;
  assign x_pos_o         = x_q;
  assign y_pos_o         = y_q;
  assign drop_o          = drop_q;
  assign ovf_o           = ovf_q;
  assign irq_o           = !fifo_empty || drop_q || ovf_q;

endmodule

// File: tb/tb_mouse_cursor_ctrl.sv
// Bench for mouse_cursor_ctrl: directed cases plus
// random packets against a queue-based reference model.
module tb_mouse_cursor_ctrl;
  import mouse_pkg::*;

  localparam int W = 640;
  localparam int H = 480;

  logic        clk = 1'b0;
  logic        rst;
  logic        center;
  logic        clr;
  logic [10:0] x;
  logic [10:0] y;
  logic        irq;
  logic        drop;
  logic        ovf;

  mouse_cursor_ctrl_if bus();

  mouse_cursor_ctrl dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus),
    .center_i (center),
    .clr_i    (clr),
    .x_pos_o  (x),
    .y_pos_o  (y),
    .irq_o    (irq),
    .drop_o   (drop),
    .ovf_o    (ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int         mx, my;
  logic [2:0] mprev;
  logic [5:0] mq[$];
  bit         mdrop, movf;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampv(int v, int lim);
    if (v < 0) return 0;
    if (v >= lim) return lim - 1;
    return v;
  endfunction

  function automatic int sx(logic [8:0] d);
    return int'($signed(d));
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mprev = 3'b000;
    mq.delete();
    mdrop = 0; movf = 0;
  endtask

  task automatic model_evt(logic [2:0] b, bit ack, bit clear);
    logic [2:0] ch;
    ch = b ^ mprev;
    if (clear) begin
      mdrop = 0;
      movf  = 0;
    end
    if (ack && mq.size() > 0) void'(mq.pop_front());
    if (ch != 3'b000) begin
      if (mq.size() < EVT_FIFO_DEPTH) mq.push_back({b, ch});
      else movf = 1;
    end
    mprev = b;
  endtask

  task automatic check_all(string tag);
    bit busy;
    busy = (mq.size() > 0);
    chk({tag, ".x"}, x, mx);
    chk({tag, ".y"}, y, my);
    chk({tag, ".evv"}, bus.evt_valid_o, busy);
    if (busy) chk({tag, ".evd"}, bus.evt_data_o, mq[0]);
    chk({tag, ".drop"}, drop, mdrop);
    chk({tag, ".ovf"}, ovf, movf);
    chk({tag, ".irq"}, irq, busy | mdrop | movf);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send_pkt(logic [8:0] dx, logic [8:0] dy,
                          logic [2:0] b, bit ack, bit clear);
    bus.pkt_valid_i = 1'b1;
    bus.dx_i = dx;
    bus.dy_i = dy;
    bus.btn_i = b;
    tick();
    bus.pkt_valid_i = 1'b0;
    chk("x_hold", x, mx);
    tick();
    mx = clampv(mx + sx(dx), W);
    chk("x_n2", x, mx);
    chk("y_hold", y, my);
    tick();
    my = clampv(my - sx(dy), H);
    chk("y_n3", y, my);
    bus.evt_ack_i = ack;
    clr = clear;
    tick();
    bus.evt_ack_i = 1'b0;
    clr = 1'b0;
    model_evt(b, ack, clear);
    check_all("pkt");
  endtask

  task automatic ack_one();
    bus.evt_ack_i = 1'b1;
    tick();
    bus.evt_ack_i = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic do_center();
    center = 1'b1;
    tick();
    center = 1'b0;
    mx = W / 2;
    my = H / 2;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mdrop = 0;
    movf = 0;
  endtask

  initial begin
    rst = 1'b1;
    center = 1'b0;
    clr = 1'b0;
    bus.pkt_valid_i = 1'b0;
    bus.dx_i = '0;
    bus.dy_i = '0;
    bus.btn_i = '0;
    bus.evt_ack_i = 1'b0;
    tick();
    do_reset();
    check_all("reset");

    // basic move, y clamps low
    send_pkt(9'd5, 9'd3, 3'b000, 0, 0);
    chk("b036.x", x, 5);
    chk("b036.y", y, 0);

    // right clamp
    do_center();
    check_all("center");
    send_pkt(9'd255, 9'd0, 3'b000, 0, 0);
    send_pkt(9'd55, 9'd0, 3'b000, 0, 0);
    chk("x630", x, 630);
    send_pkt(9'd20, 9'd0, 3'b000, 0, 0);
    chk("x639", x, 639);

    // left clamp
    do_reset();
    send_pkt(9'd3, 9'd0, 3'b000, 0, 0);
    send_pkt(9'h1F8, 9'd0, 3'b000, 0, 0);
    chk("x0", x, 0);

    // button events and acks
    send_pkt(9'd0, 9'd0, 3'b001, 0, 0);
    chk("ev1", bus.evt_data_o, 6'b001_001);
    send_pkt(9'd0, 9'd0, 3'b000, 0, 0);
    ack_one();
    check_all("ack1");
    chk("ev2", bus.evt_data_o, 6'b000_001);
    ack_one();
    check_all("ack2");
    chk("irq_low", irq, 0);

    // overflow, clear, full push+pop, clear vs set
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_pkt(9'd0, 9'd0, (i % 2 == 0) ? 3'b001 : 3'b000, 0, 0);
    end
    chk("ovf_set", ovf, 1);
    do_clr();
    check_all("clr");
    chk("irq_stay", irq, 1);
    send_pkt(9'd0, 9'd0, 3'b100, 1, 0);
    chk("fullpp.ovf", ovf, 0);
    send_pkt(9'd0, 9'd0, 3'b000, 0, 1);
    chk("clr_vs_set", ovf, 1);

    // back-to-back packet is dropped
    do_reset();
    bus.pkt_valid_i = 1'b1;
    bus.dx_i = 9'd10;
    bus.dy_i = 9'h1FE;
    bus.btn_i = 3'b010;
    tick();
    bus.dx_i = 9'd50;
    bus.btn_i = 3'b111;
    tick();
    bus.pkt_valid_i = 1'b0;
    tick();
    tick();
    mx = 10;
    my = 2;
    mdrop = 1;
    model_evt(3'b010, 0, 0);
    check_all("drop2");

    // centre wins over packet
    do_clr();
    center = 1'b1;
    bus.pkt_valid_i = 1'b1;
    bus.dx_i = 9'd7;
    tick();
    center = 1'b0;
    bus.pkt_valid_i = 1'b0;
    mx = 320;
    my = 240;
    mdrop = 1;
    check_all("cwin");
    for (int i = 0; i < 4; i++) tick();
    check_all("cwin_late");

    // centre outside idle is ignored
    do_clr();
    bus.pkt_valid_i = 1'b1;
    bus.dx_i = 9'd4;
    bus.dy_i = 9'd4;
    bus.btn_i = 3'b010;
    tick();
    bus.pkt_valid_i = 1'b0;
    center = 1'b1;
    tick();
    center = 1'b0;
    tick();
    tick();
    mx = 324;
    my = 236;
    model_evt(3'b010, 0, 0);
    check_all("cbusy");

    // reset during CALC_Y
    bus.pkt_valid_i = 1'b1;
    bus.dx_i = 9'd30;
    bus.dy_i = 9'h1F0;
    bus.btn_i = 3'b101;
    tick();
    bus.pkt_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_all("rst_mid");
    for (int i = 0; i < 3; i++) tick();
    check_all("rst_late");
    send_pkt(9'd1, 9'h1FF, 3'b000, 0, 0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0) begin
        do_center();
        check_all("r.center");
      end else if (r == 1) begin
        do_clr();
        check_all("r.clr");
      end else begin
        send_pkt(9'($urandom), 9'($urandom), 3'($urandom),
                 bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0));
      end
      if ($urandom_range(0, 1) == 1) begin
        ack_one();
        check_all("r.ack");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mouse_cursor_ctrl.md
MOUSE_CURSOR_CTRL -- requirements
Module: mouse_cursor_ctrl

Interface
REQ-001 Parameter WIDTH, default 640, screen width in pixels; X range [0, WIDTH-1].
REQ-002 Parameter HEIGHT, default 480, screen height in pixels; Y range [0, HEIGHT-1].
REQ-003 Parameter X_POS_WIDTH, default 10; x_pos_o is X_POS_WIDTH+1 bits.
REQ-004 Parameter Y_POS_WIDTH, default 10; y_pos_o is Y_POS_WIDTH+1 bits.
REQ-005 The block SHALL use one clock, clk_i, and a synchronous, active-high reset, rst_i.
REQ-006 clk_i  in  1  system clock.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 pkt_valid_i  in  1  one-cycle tick: mouse packet complete.
REQ-009 dx_i  in  9  two's-complement X delta, valid with pkt_valid_i.
REQ-010 dy_i  in  9  two's-complement Y delta, PS/2 convention (+ = up).
REQ-011 btn_i  in  3  button state {mid, right, left}, valid with pkt_valid_i.
REQ-012 center_i  in  1  one-cycle request: move cursor to screen centre.
REQ-013 x_pos_o  out  X_POS_WIDTH+1  clamped cursor X.
REQ-014 y_pos_o  out  Y_POS_WIDTH+1  clamped cursor Y (+ = down).
REQ-015 evt_valid_o  out  1  event FIFO non-empty.
REQ-016 evt_data_o  out  6  head event {btn_new[2:0], btn_changed[2:0]}.
REQ-017 evt_ack_i  in  1  pop head event; ignored when empty.
REQ-018 irq_o  out  1  level interrupt = evt_valid_o OR any sticky flag.
REQ-019 drop_o  out  1  sticky: packet discarded while busy.
REQ-020 ovf_o  out  1  sticky: event discarded, FIFO full.
REQ-021 clr_i  in  1  one-cycle clear of drop_o and ovf_o.

Function
REQ-022 FSM states SHALL be IDLE, CALC_X, CALC_Y, EVENT; IDLE->CALC_X on accepted packet, then CALC_Y, EVENT, IDLE unconditionally.
REQ-023 In IDLE, pkt_valid_i SHALL latch dx_i, dy_i, btn_i (cycle N); x_pos_o updates visible N+2, y_pos_o N+3, event visible N+4; back in IDLE at N+4.
REQ-024 A single shared signed adder of max(X_POS_WIDTH,Y_POS_WIDTH)+3 bits SHALL be used: CALC_X computes x+sext(dx), CALC_Y computes y-sext(dy).
REQ-025 Clamp: result <0 -> 0; result >= WIDTH (HEIGHT) -> WIDTH-1 (HEIGHT-1); else result.
REQ-026 EVENT SHALL push {btn_latched, btn_latched XOR btn_prev} only if changed mask non-zero; btn_prev updated to btn_latched in EVENT regardless.
REQ-027 pkt_valid_i outside IDLE SHALL be discarded and set drop_o.
REQ-028 center_i in IDLE SHALL set x=WIDTH/2, y=HEIGHT/2 next cycle; center_i outside IDLE ignored.
REQ-029 center_i and pkt_valid_i same IDLE cycle: centre wins, packet discarded, drop_o set.
REQ-030 Event FIFO depth 4, first-word fall-through; evt_data_o valid whenever evt_valid_o.
REQ-031 Push while full: event discarded, ovf_o set; push and pop same cycle when full: both succeed, count unchanged.
REQ-032 clr_i coincident with a set condition: set wins.

Reset
REQ-033 rst_i SHALL force IDLE, x_pos_o=0, y_pos_o=0, btn_prev=0, FIFO empty, evt_valid_o=0, drop_o=0, ovf_o=0, irq_o=0; mid-sequence reset abandons the packet with no partial update after reset.

Structure
REQ-034 Package mouse_pkg SHALL hold the FSM state enum, event struct (btn_new, btn_changed), EVT_FIFO_DEPTH=4.
REQ-035 FIFO SHALL be sub-module mouse_evt_fifo (parameterised depth/width, full/empty, simultaneous push/pop).

Verification
REQ-036 Reset; packet dx=+5, dy=+3, btn=0 at N -> x_pos_o=5 at N+2, y_pos_o=0 (clamped) at N+3, no event.
REQ-037 From x=630, dx=+20 -> x=639; from x=3, dx=-8 (0x1F8) -> x=0.
REQ-038 btn=3'b001 packet then btn=3'b000 packet -> events {001,001} then {000,001}; evt_ack_i pops each; irq_o falls after second pop.
REQ-039 Five button-change packets without ack -> 4 events queued, ovf_o=1; clr_i -> ovf_o=0, irq_o stays 1.
REQ-040 pkt_valid_i at N and N+1 -> second dropped, drop_o=1; center_i with pkt_valid_i in IDLE -> x=320, y=240, drop_o=1.
REQ-041 rst_i asserted in CALC_Y -> next cycle IDLE, x=y=0, FIFO empty.
